// File: rtl/fsrc_pkg.sv
// Shared types and sizing helpers for the TX fractional sample-rate phase generator.
package fsrc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_STOPPING
    } fsrc_state_e;

    // Headroom for NUM_SAMPLES rate steps on top of the accumulator, plus one carry bit.
    function automatic int sum_width(input int accum_width, input int num_samples);
        return accum_width + $clog2(num_samples) + 1;
    endfunction

endpackage

// File: rtl/fsrc_phase_step.sv
// Combinational lookahead: per-sample partial sums, hold mask and wrapped next accumulator.
module fsrc_phase_step
    import fsrc_pkg::*;
#(
    parameter int ACCUM_WIDTH = 64,
    parameter int NUM_SAMPLES = 16
) (
    input  logic [ACCUM_WIDTH-1:0] acc,
    input  logic [ACCUM_WIDTH-1:0] rate,
    output logic [NUM_SAMPLES-1:0] hold_mask,
    output logic [ACCUM_WIDTH-1:0] acc_next
);

    localparam int SW = sum_width(ACCUM_WIDTH, NUM_SAMPLES);

    // s[0] is the incoming accumulator, s[k+1] is the sum after sample k.
    logic [NUM_SAMPLES:0][SW-1:0] s;

    assign s[0] = SW'(acc);

    generate
        for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_smp
            assign s[k+1]       = SW'(acc) + SW'(k + 1) * SW'(rate);
            assign hold_mask[k] = s[k+1][SW-1:ACCUM_WIDTH] != s[k][SW-1:ACCUM_WIDTH];
        end
    endgenerate

    assign acc_next = s[NUM_SAMPLES][ACCUM_WIDTH-1:0];

endmodule

// File: rtl/fsrc_tx_phase_gen.sv
// TX FSRC phase-accumulator engine: FSM, shadowed rate, registered hold-mask beats, hold stats.
module fsrc_tx_phase_gen
    import fsrc_pkg::*;
#(
    parameter int ACCUM_WIDTH = 64,
    parameter int NUM_SAMPLES = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   ext_trig_en,
    input  logic                   trig,
    input  logic                   stop,
    input  logic                   accum_set,
    input  logic [ACCUM_WIDTH-1:0] accum_set_val,
    input  logic                   change_rate,
    input  logic [ACCUM_WIDTH-1:0] add_val,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NUM_SAMPLES-1:0] m_hold_mask,
    output logic                   running,
    output logic [CNT_WIDTH-1:0]   hold_count,
    output logic                   set_ignored
);

    localparam int PW = $clog2(NUM_SAMPLES + 1);

    fsrc_state_e state, state_n;

    logic [ACCUM_WIDTH-1:0] acc, rate, shadow, rate_step, acc_next;
    logic [NUM_SAMPLES-1:0] mask_next;
    logic                   adv, accept;
    logic [PW-1:0]          pop;
    logic [CNT_WIDTH:0]     cnt_sum;

    assign accept  = m_valid && m_ready;
    assign adv     = enable && (state == ST_RUN) && (!m_valid || m_ready);
    assign running = (state == ST_RUN);

    // The shadow is promoted on the advance itself, so the new rate governs that whole beat.
    assign rate_step = adv ? shadow : rate;

    fsrc_phase_step #(
        .ACCUM_WIDTH(ACCUM_WIDTH),
        .NUM_SAMPLES(NUM_SAMPLES)
    ) u_step (
        .acc      (acc),
        .rate     (rate_step),
        .hold_mask(mask_next),
        .acc_next (acc_next)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     if (!stop) state_n = ext_trig_en ? ST_ARMED : ST_RUN;
            ST_ARMED:    if (stop) state_n = ST_IDLE;
                         else if (trig) state_n = ST_RUN;
            ST_RUN:      if (stop) state_n = ST_STOPPING;
            ST_STOPPING: if (!m_valid || m_ready) state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
        if (!enable) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc    <= '0;
            rate   <= '0;
            shadow <= '0;
        end else begin
            if (change_rate) shadow <= add_val;
            if (adv || state == ST_IDLE || state == ST_ARMED) rate <= shadow;
            if (adv)                                   acc <= acc_next;
            else if (accum_set && state != ST_RUN)     acc <= accum_set_val;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                      set_ignored <= 1'b0;
        else if (state_n == ST_IDLE && state != ST_IDLE)  set_ignored <= 1'b0;
        else if (accum_set && state == ST_RUN)            set_ignored <= 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid     <= 1'b0;
            m_hold_mask <= '0;
        end else if (!enable) begin
            m_valid <= 1'b0;
        end else if (adv) begin
            m_valid     <= 1'b1;
            m_hold_mask <= mask_next;
        end else if (accept) begin
            m_valid <= 1'b0;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) pop = pop + PW'(m_hold_mask[i]);
    end

    assign cnt_sum = {1'b0, hold_count} + (CNT_WIDTH + 1)'(pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     hold_count <= '0;
        else if (accept) hold_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

endmodule

// File: doc/fsrc_tx_phase_gen.md
Name: fsrc_tx_phase_gen

Overview:
- Parametrised phase-accumulator engine for the TX fractional sample-rate converter.
- Each cycle it advances a fixed-point accumulator by NUM_SAMPLES steps of a programmable rate and emits a per-sample hold mask; 1 = insert a hold/hole sample. The downstream sample mux uses this mask.
- Compared with the current TX path it adds: multi-sample-per-beat lookahead, external-trigger arming, a shadowed rate register applied on a beat boundary, graceful stop, and hold statistics.
- Sits between the FSRC regmap and the per-converter TX data mux.

Parameters:
- ACCUM_WIDTH, 64, accumulator and rate width in bits (fraction of one sample period).
- NUM_SAMPLES, 16, samples handled per beat; hold mask width.
- CNT_WIDTH, 32, width of the saturating hold counter.

Ports:
- clk  in  1  core clock.
- resetn  in  1  reset; one clock, asynchronous, active-low.
- enable  in  1  level; 0 forces IDLE.
- ext_trig_en  in  1  1 = wait for trig before running; 0 = run immediately when enabled.
- trig  in  1  single-cycle start trigger.
- stop  in  1  single-cycle stop request.
- accum_set  in  1  pulse; load accum_set_val.
- accum_set_val  in  ACCUM_WIDTH  accumulator preset.
- change_rate  in  1  pulse; capture add_val into the shadow register.
- add_val  in  ACCUM_WIDTH  rate step per sample.
- m_valid  out  1  hold-mask beat valid.
- m_ready  in  1  downstream accept.
- m_hold_mask  out  NUM_SAMPLES  bit k = sample k of the beat is a hold.
- running  out  1  state == RUN.
- hold_count  out  CNT_WIDTH  saturating count of hold bits emitted.
- set_ignored  out  1  sticky; accum_set arrived while in RUN. Cleared on IDLE entry.

Behaviour:
- Reset values: all outputs 0; acc = 0; rate and shadow = 0; state IDLE.
- States:
  - IDLE: waiting for enable.
  - ARMED: waiting for trig.
  - RUN: producing beats.
  - STOPPING: draining the pending beat.
- Transitions:
  - IDLE -> ARMED when enable && ext_trig_en.
  - IDLE -> RUN when enable && !ext_trig_en.
  - ARMED -> RUN on trig.
  - RUN -> STOPPING on stop.
  - STOPPING -> IDLE once m_valid == 0, or on the cycle the pending beat is accepted.
  - Any state -> IDLE on enable == 0; m_valid is cleared the same cycle.
- Beat advance: a new beat is computed when state == RUN && (!m_valid || m_ready). Output is registered; latency 1 cycle from the advance condition to m_valid. No beat is generated in STOPPING.
- Handshake: m_valid, once high, holds m_hold_mask stable until m_ready.
- Arithmetic, computed at width ACCUM_WIDTH + clog2(NUM_SAMPLES) + 1:
  - S_k = acc + (k+1)*rate, for k = 0..NUM_SAMPLES-1.
  - hold_k = (S_k >> ACCUM_WIDTH) != (S_{k-1} >> ACCUM_WIDTH), with S_{-1} = acc.
  - Next acc = S_{NUM_SAMPLES-1} mod 2^ACCUM_WIDTH (wrap-around).
  - rate < 2^ACCUM_WIDTH, so each sample has at most one wrap.
- Rate shadowing: change_rate loads shadow <= add_val in any state. rate <= shadow at:
  - every beat advance, before computing (new rate used from that beat);
  - IDLE/ARMED every cycle.
  A change mid-beat never splits a beat.
- accum_set:
  - IDLE/ARMED/STOPPING: acc <= accum_set_val next cycle.
  - RUN: ignored and set_ignored <= 1.
  - accum_set and an advance in the same cycle cannot occur (RUN only).
- stop coincident with trig in ARMED: stop wins; go to IDLE.
- stop while in IDLE/ARMED: go to IDLE.
- hold_count += popcount(m_hold_mask) on each accepted beat. Saturates at all-ones. Cleared only by resetn.
- Async reset mid-beat: m_valid drops immediately; no partial beat survives.

Decomposition:
- Package fsrc_pkg: state enum typedef (IDLE/ARMED/RUN/STOPPING), and a localparam function for the sum width (ACCUM_WIDTH + clog2(NUM_SAMPLES) + 1).
- Sub-module fsrc_phase_step: combinational S_k / hold mask / next-acc generator, parametrised on ACCUM_WIDTH and NUM_SAMPLES. The top holds the FSM, registers, skid logic and counters.

Test Plan (ACCUM_WIDTH=16, NUM_SAMPLES=4):
- add_val=0x4000, change_rate, enable=1, ext_trig_en=0, m_ready=1 -> running=1 one cycle later. Every beat mask 4'b1000. hold_count=10 after 10 beats.
- add_val=0x8000 from acc=0 -> masks 4'b1010 repeating. Then accum_set_val=0xC000 in IDLE, rerun -> first mask 4'b0101.
- add_val=0x5555 -> hold bits total 1/3 of samples ±1 over 300 samples. Acc wraps without glitch.
- ext_trig_en=1, enable=1 -> state ARMED, m_valid stays 0. trig -> first m_valid 2 cycles later.
- m_ready held 0 for 5 cycles -> mask stable, acc frozen. change_rate to 0x0000 during the stall -> the next computed beat is 4'b0000.
- accum_set during RUN -> acc unchanged, set_ignored=1. stop with m_ready=0 -> STOPPING until accept, then IDLE. Async resetn pulse mid-run -> m_valid=0 immediately.
